// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
// Shared definitions for the audio sample fetch controller:
//   - fetch FSM state encoding
//   - host register window addresses and control bit positions
//   - desync detection threshold and frame counter width
//   - packed status register layout
// -----------------------------------------------------------------------------
package audio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_POP     = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_HOLD    = 2'd3
    } fetch_state_t;

    // Byte-wide host register window
    localparam int ADDR_L0   = 0;
    localparam int ADDR_L1   = 1;
    localparam int ADDR_L2   = 2;
    localparam int ADDR_R0   = 3;
    localparam int ADDR_R1   = 4;
    localparam int ADDR_R2   = 5;
    localparam int ADDR_STAT = 6;
    localparam int ADDR_CTRL = 7;

    // Control register bit positions
    localparam int CTRL_EN      = 0;
    localparam int CTRL_IRQ_EN  = 1;
    localparam int CTRL_CLR_ERR = 2;

    // Consecutive one-sided-empty cycles in IDLE before desync is flagged
    localparam int DESYNC_CYCLES = 4;

    localparam int FRAME_CNT_W = 8;

    // Status register payload, LSB first: hold_valid, l_empty, r_empty,
    // underrun, desync. Upper bits of the register read as zero.
    typedef struct packed {
        logic desync;
        logic underrun;
        logic r_empty;
        logic l_empty;
        logic hold_valid;
    } stat_bits_t;

endpackage

// File: rtl/audio_fetch_regs.sv
// -----------------------------------------------------------------------------
// audio_fetch_regs
// Control/status register file and host read mux for the audio fetch
// controller. Holds the captured stereo frame, frame counter, error flags
// and control bits, and derives the frame-consume pulse for the FSM.
//
// Ports:
//   i_clk, i_reset        system clock, synchronous active-high reset
//   i_address/i_read/
//   i_write/i_datain      registered host access
//   o_dataout             combinational read mux
//   i_l_rdempty/
//   i_r_rdempty           FIFO empty flags (reported in status)
//   i_capture             FSM is in CAPTURE: latch FIFO outputs this cycle
//   i_lsample/i_rsample   FIFO q data
//   i_desync_evt          desync condition met this cycle
//   o_en                  fetch enable
//   o_consume             host read of the last byte with a frame held
//   o_frame_irq           registered hold_valid & irq_en
// -----------------------------------------------------------------------------
module audio_fetch_regs
    import audio_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 3,
    parameter int DATA_WIDTH    = 8,
    parameter int AUD_BIT_DEPTH = 24
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [ADDRESS_WIDTH-1:0] i_address,
    input  logic                     i_read,
    input  logic                     i_write,
    input  logic [DATA_WIDTH-1:0]    i_datain,
    output logic [DATA_WIDTH-1:0]    o_dataout,
    input  logic                     i_l_rdempty,
    input  logic                     i_r_rdempty,
    input  logic                     i_capture,
    input  logic [AUD_BIT_DEPTH-1:0] i_lsample,
    input  logic [AUD_BIT_DEPTH-1:0] i_rsample,
    input  logic                     i_desync_evt,
    output logic                     o_en,
    output logic                     o_consume,
    output logic                     o_frame_irq
);

    logic [AUD_BIT_DEPTH-1:0] r_lhold;
    logic [AUD_BIT_DEPTH-1:0] r_rhold;
    logic                     r_hold_valid;
    logic [FRAME_CNT_W-1:0]   r_frame_cnt;
    logic                     r_en;
    logic                     r_irq_en;
    logic                     r_underrun;
    logic                     r_desync;
    logic                     r_frame_irq;

    logic       w_rd_last;
    logic       w_underrun_evt;
    logic       w_ctrl_wr;
    logic       w_clr_err;
    stat_bits_t w_stat;
    logic       w_unused;

    // Only the low control bits are defined; the rest of the write byte is dropped.
    assign w_unused = &{1'b0, i_datain[DATA_WIDTH-1:CTRL_CLR_ERR+1]};

    // The last byte of the frame is the consume point.
    assign w_rd_last      = i_read && (i_address == ADDRESS_WIDTH'(ADDR_R2));
    assign o_consume      = w_rd_last && r_hold_valid;
    assign w_underrun_evt = w_rd_last && !r_hold_valid;

    assign w_ctrl_wr = i_write && (i_address == ADDRESS_WIDTH'(ADDR_CTRL));
    assign w_clr_err = w_ctrl_wr && i_datain[CTRL_CLR_ERR];

    assign o_en        = r_en;
    assign o_frame_irq = r_frame_irq;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_lhold      <= '0;
            r_rhold      <= '0;
            r_hold_valid <= 1'b0;
            r_frame_cnt  <= '0;
            r_en         <= 1'b0;
            r_irq_en     <= 1'b0;
            r_underrun   <= 1'b0;
            r_desync     <= 1'b0;
            r_frame_irq  <= 1'b0;
        end else begin
            if (w_ctrl_wr) begin
                r_en     <= i_datain[CTRL_EN];
                r_irq_en <= i_datain[CTRL_IRQ_EN];
            end

            // Capture and consume are mutually exclusive: capture only
            // happens while nothing is held.
            if (i_capture) begin
                r_lhold      <= i_lsample;
                r_rhold      <= i_rsample;
                r_hold_valid <= 1'b1;
                r_frame_cnt  <= r_frame_cnt + FRAME_CNT_W'(1);
            end else if (o_consume) begin
                r_hold_valid <= 1'b0;
            end

            // A new error event takes priority over a simultaneous clear.
            if (w_underrun_evt)
                r_underrun <= 1'b1;
            else if (w_clr_err)
                r_underrun <= 1'b0;

            if (i_desync_evt)
                r_desync <= 1'b1;
            else if (w_clr_err)
                r_desync <= 1'b0;

            r_frame_irq <= r_hold_valid & r_irq_en;
        end
    end

    assign w_stat = '{desync:     r_desync,
                      underrun:   r_underrun,
                      r_empty:    i_r_rdempty,
                      l_empty:    i_l_rdempty,
                      hold_valid: r_hold_valid};

    always_comb begin
        o_dataout = '0;
        case (i_address)
            ADDRESS_WIDTH'(ADDR_L0):   o_dataout = r_lhold[DATA_WIDTH-1:0];
            ADDRESS_WIDTH'(ADDR_L1):   o_dataout = r_lhold[2*DATA_WIDTH-1:DATA_WIDTH];
            ADDRESS_WIDTH'(ADDR_L2):   o_dataout = r_lhold[3*DATA_WIDTH-1:2*DATA_WIDTH];
            ADDRESS_WIDTH'(ADDR_R0):   o_dataout = r_rhold[DATA_WIDTH-1:0];
            ADDRESS_WIDTH'(ADDR_R1):   o_dataout = r_rhold[2*DATA_WIDTH-1:DATA_WIDTH];
            ADDRESS_WIDTH'(ADDR_R2):   o_dataout = r_rhold[3*DATA_WIDTH-1:2*DATA_WIDTH];
            ADDRESS_WIDTH'(ADDR_STAT): o_dataout = DATA_WIDTH'(w_stat);
            ADDRESS_WIDTH'(ADDR_CTRL): o_dataout = DATA_WIDTH'(r_frame_cnt);
            default:                   o_dataout = '0;
        endcase
    end

endmodule

// File: rtl/audio_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// audio_fetch_ctrl
// Pops the left/right audio FIFOs in lockstep, holds one stereo frame and
// exposes it as byte registers to the host. The host releases the frame by
// reading its last byte; only then is the next pair popped. Reports a desync
// when exactly one FIFO stays empty while enabled, and an underrun when the
// host reads the last byte with nothing held.
//
// Ports:
//   i_clk, i_reset           system clock (also FIFO read clock), sync reset
//   i_address, i_read,
//   i_write, i_datain        registered host register access
//   o_dataout                combinational register read data
//   i_l_rdempty/i_r_rdempty  FIFO empty flags
//   i_lsound_fifo/
//   i_rsound_fifo            FIFO q, valid the cycle after a pop
//   o_l_read/o_r_read        FIFO pops (one cycle, always together)
//   o_frame_irq              level interrupt while a frame is held
// -----------------------------------------------------------------------------
module audio_fetch_ctrl
    import audio_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 3,
    parameter int DATA_WIDTH    = 8,
    parameter int AUD_BIT_DEPTH = 24
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [ADDRESS_WIDTH-1:0] i_address,
    input  logic                     i_read,
    input  logic                     i_write,
    input  logic [DATA_WIDTH-1:0]    i_datain,
    output logic [DATA_WIDTH-1:0]    o_dataout,
    input  logic                     i_l_rdempty,
    input  logic                     i_r_rdempty,
    input  logic [AUD_BIT_DEPTH-1:0] i_lsound_fifo,
    input  logic [AUD_BIT_DEPTH-1:0] i_rsound_fifo,
    output logic                     o_l_read,
    output logic                     o_r_read,
    output logic                     o_frame_irq
);

    localparam int MIS_W = $clog2(DESYNC_CYCLES) + 1;

    fetch_state_t     r_state;
    logic             r_l_read;
    logic             r_r_read;
    logic [MIS_W-1:0] r_mis_cnt;

    logic w_en;
    logic w_consume;
    logic w_capture;
    logic w_both_ready;
    logic w_mismatch;
    logic w_desync_evt;

    assign w_capture    = (r_state == ST_CAPTURE);
    assign w_both_ready = !i_l_rdempty && !i_r_rdempty;
    // Desync is only judged while waiting to pop, with fetching enabled.
    assign w_mismatch   = (r_state == ST_IDLE) && w_en && (i_l_rdempty ^ i_r_rdempty);
    // r_mis_cnt holds the number of preceding mismatch cycles, so this
    // fires on the DESYNC_CYCLES-th consecutive one.
    assign w_desync_evt = w_mismatch && (r_mis_cnt >= MIS_W'(DESYNC_CYCLES - 1));

    assign o_l_read = r_l_read;
    assign o_r_read = r_r_read;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_l_read  <= 1'b0;
            r_r_read  <= 1'b0;
            r_mis_cnt <= '0;
        end else begin
            r_l_read <= 1'b0;
            r_r_read <= 1'b0;

            if (!w_mismatch)
                r_mis_cnt <= '0;
            else if (r_mis_cnt < MIS_W'(DESYNC_CYCLES - 1))
                r_mis_cnt <= r_mis_cnt + MIS_W'(1);

            case (r_state)
                ST_IDLE: begin
                    if (w_en && w_both_ready) begin
                        r_state  <= ST_POP;
                        r_l_read <= 1'b1;   // pop strobe lives exactly in POP
                        r_r_read <= 1'b1;
                    end
                end
                ST_POP:     r_state <= ST_CAPTURE;
                ST_CAPTURE: r_state <= ST_HOLD;
                ST_HOLD: begin
                    if (w_consume)
                        r_state <= ST_IDLE;
                end
                default:    r_state <= ST_IDLE;
            endcase
        end
    end

    audio_fetch_regs #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH),
        .AUD_BIT_DEPTH (AUD_BIT_DEPTH)
    ) u_regs (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_address    (i_address),
        .i_read       (i_read),
        .i_write      (i_write),
        .i_datain     (i_datain),
        .o_dataout    (o_dataout),
        .i_l_rdempty  (i_l_rdempty),
        .i_r_rdempty  (i_r_rdempty),
        .i_capture    (w_capture),
        .i_lsample    (i_lsound_fifo),
        .i_rsample    (i_rsound_fifo),
        .i_desync_evt (w_desync_evt),
        .o_en         (w_en),
        .o_consume    (w_consume),
        .o_frame_irq  (o_frame_irq)
    );

endmodule

// File: tb/tb_audio_fetch_ctrl.sv
module tb_audio_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  addr = '0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [7:0]  din = '0;
    logic [7:0]  dout;
    logic        le = 1'b1;
    logic        re = 1'b1;
    logic [23:0] lq_d = '0;
    logic [23:0] rq_d = '0;
    logic        lrd, rrd, irq;

    always #5 clk = ~clk;

    audio_fetch_ctrl #(
        .ADDRESS_WIDTH (3),
        .DATA_WIDTH    (8),
        .AUD_BIT_DEPTH (24)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_address     (addr),
        .i_read        (rd),
        .i_write       (wr),
        .i_datain      (din),
        .o_dataout     (dout),
        .i_l_rdempty   (le),
        .i_r_rdempty   (re),
        .i_lsound_fifo (lq_d),
        .i_rsound_fifo (rq_d),
        .o_l_read      (lrd),
        .o_r_read      (rrd),
        .o_frame_irq   (irq)
    );

    int n_vec = 0;
    int n_err = 0;

    // FIFO environment
    logic [23:0] lq[$];
    logic [23:0] rq[$];

    // Behavioural model. m_age counts cycles since the pop of the frame in
    // flight: -1 none in flight, 0 pop cycle, 1 data cycle, 2 held.
    bit          m_en, m_irqen, m_held, m_under, m_desync, m_irq;
    int          m_age, m_run, m_cnt;
    logic [23:0] m_l, m_r;
    logic [7:0]  last_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_en = 0; m_irqen = 0; m_held = 0; m_under = 0; m_desync = 0; m_irq = 0;
        m_age = -1; m_run = 0; m_cnt = 0; m_l = '0; m_r = '0;
    endtask

    function automatic logic [7:0] m_dout();
        logic [23:0] l, r;
        l = m_l; r = m_r;
        case (addr)
            3'd0: return l[7:0];
            3'd1: return l[15:8];
            3'd2: return l[23:16];
            3'd3: return r[7:0];
            3'd4: return r[15:8];
            3'd5: return r[23:16];
            3'd6: return {3'b000, m_desync, m_under, re, le, m_held};
            default: return 8'(m_cnt);
        endcase
    endfunction

    task automatic model_step();
        bit rd_last, consume, under_set, mis, des_set, cw, clr;
        if (rst) begin
            model_reset();
            return;
        end
        rd_last   = rd && (addr == 3'd5);
        consume   = rd_last && m_held;
        under_set = rd_last && !m_held;
        mis       = m_en && (m_age < 0) && (le != re);
        des_set   = mis && (m_run >= 3);
        m_run     = mis ? m_run + 1 : 0;
        cw        = wr && (addr == 3'd7);
        clr       = cw && din[2];
        m_irq     = m_held && m_irqen;
        if (clr) begin m_under = 0; m_desync = 0; end
        if (under_set) m_under = 1;
        if (des_set) m_desync = 1;
        if (m_age < 0) begin
            if (m_en && !le && !re) m_age = 0;
        end else if (m_age == 0) begin
            m_age = 1;
        end else if (m_age == 1) begin
            m_l = lq_d; m_r = rq_d; m_held = 1; m_cnt = (m_cnt + 1) % 256; m_age = 2;
        end else if (consume) begin
            m_held = 0; m_age = -1;
        end
        if (cw) begin m_en = din[0]; m_irqen = din[1]; end
    endtask

    task automatic env_flags();
        le = (lq.size() == 0);
        re = (rq.size() == 0);
    endtask

    // One clock: compare at the falling edge, advance model at the rising
    // edge, then let the FIFOs respond to the pops the DUT issued.
    task automatic cycle();
        bit pl, pr;
        @(negedge clk);
        chk("l_read", lrd, (m_age == 0));
        chk("r_read", rrd, (m_age == 0));
        chk("frame_irq", irq, m_irq);
        chk("dataout", dout, m_dout());
        last_rd = dout;
        pl = lrd; pr = rrd;
        @(posedge clk);
        model_step();
        #1;
        if (pl && lq.size() > 0) lq_d = lq.pop_front();
        if (pr && rq.size() > 0) rq_d = rq.pop_front();
        env_flags();
    endtask

    task automatic host_rd(input logic [2:0] a, output logic [7:0] d);
        addr = a; rd = 1'b1;
        cycle();
        rd = 1'b0;
        d = last_rd;
    endtask

    task automatic host_wr(input logic [2:0] a, input logic [7:0] v);
        addr = a; din = v; wr = 1'b1;
        cycle();
        wr = 1'b0;
    endtask

    task automatic push(input bit pl, input bit pr, input logic [23:0] l, input logic [23:0] r);
        if (pl) lq.push_back(l);
        if (pr) rq.push_back(r);
        env_flags();
    endtask

    task automatic wait_held(input int budget);
        int n = 0;
        while (!m_held && n < budget) begin cycle(); n++; end
        chk("frame_held_in_time", m_held, 1);
    endtask

    task automatic drain(input logic [23:0] l, input logic [23:0] r);
        logic [7:0] d;
        logic [23:0] lv, rv;
        lv = l; rv = r;
        host_rd(3'd0, d); chk("L0", d, lv[7:0]);
        host_rd(3'd1, d); chk("L1", d, lv[15:8]);
        host_rd(3'd2, d); chk("L2", d, lv[23:16]);
        host_rd(3'd3, d); chk("R0", d, rv[7:0]);
        host_rd(3'd4, d); chk("R1", d, rv[15:8]);
        host_rd(3'd5, d); chk("R2", d, rv[23:16]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0]  d;
        logic [23:0] fl[3];
        logic [23:0] fr[3];
        logic [23:0] a, b;

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Reset state
        host_rd(3'd6, d); chk("rst_status", d, 8'h06);
        host_rd(3'd7, d); chk("rst_frame_cnt", d, 8'h00);
        chk("rst_irq", irq, 0);

        // Single frame with known bytes
        push(1, 1, 24'h123456, 24'hABCDEF);
        host_wr(3'd7, 8'h03);
        wait_held(10);
        cycle();
        chk("irq_up", irq, 1);
        host_rd(3'd0, d); chk("lit_L0", d, 8'h56);
        host_rd(3'd1, d); chk("lit_L1", d, 8'h34);
        host_rd(3'd2, d); chk("lit_L2", d, 8'h12);
        host_rd(3'd3, d); chk("lit_R0", d, 8'hEF);
        host_rd(3'd4, d); chk("lit_R1", d, 8'hCD);
        host_rd(3'd5, d); chk("lit_R2", d, 8'hAB);
        cycle();
        chk("irq_down", irq, 0);

        // Three preloaded frames drained in order
        do_reset();
        for (int i = 0; i < 3; i++) begin
            fl[i] = 24'($urandom); fr[i] = 24'($urandom);
            push(1, 1, fl[i], fr[i]);
        end
        host_wr(3'd7, 8'h03);
        for (int i = 0; i < 3; i++) begin
            wait_held(10);
            drain(fl[i], fr[i]);
        end
        repeat (3) cycle();
        host_rd(3'd7, d); chk("cnt_3", d, 8'h03);
        host_rd(3'd6, d); chk("idle_status", d, 8'h06);

        // Underrun and error clear
        host_wr(3'd7, 8'h00);
        push(1, 1, 24'h00A5A5, 24'h005A5A);
        host_rd(3'd5, d);
        host_rd(3'd6, d); chk("underrun_status", d, 8'h08);
        host_wr(3'd7, 8'h05);
        host_rd(3'd6, d); chk("cleared_status", d, 8'h00);
        wait_held(10);
        drain(24'h00A5A5, 24'h005A5A);

        // Desync: four one-sided cycles set it, three do not
        push(1, 0, 24'h111111, 24'h0);
        repeat (3) cycle();
        host_rd(3'd6, d); chk("desync_cycle4_pending", d, 8'h04);
        host_rd(3'd6, d); chk("desync_set", d, 8'h14);
        push(0, 1, 24'h0, 24'h222222);
        wait_held(10);
        drain(24'h111111, 24'h222222);
        host_wr(3'd7, 8'h05);
        host_rd(3'd6, d); chk("desync_cleared", d, 8'h06);
        push(1, 0, 24'h333333, 24'h0);
        repeat (3) cycle();
        push(0, 1, 24'h0, 24'h444444);
        cycle();
        host_rd(3'd6, d); chk("no_desync", d[4], 0);
        wait_held(10);
        drain(24'h333333, 24'h444444);

        // Reset while holding a frame
        host_wr(3'd7, 8'h03);
        push(1, 1, 24'h555555, 24'h666666);
        wait_held(10);
        cycle();
        chk("irq_before_rst", irq, 1);
        do_reset();
        chk("irq_after_rst", irq, 0);
        host_rd(3'd6, d); chk("hold_after_rst", d[0], 0);
        host_rd(3'd7, d); chk("cnt_after_rst", d, 8'h00);
        push(1, 1, 24'h777777, 24'h888888);
        repeat (6) cycle();
        chk("no_pop_without_en", m_held, 0);
        host_wr(3'd7, 8'h01);
        wait_held(10);
        drain(24'h777777, 24'h888888);

        // Frame counter wrap
        do_reset();
        host_wr(3'd7, 8'h01);
        for (int i = 0; i < 256; i++) begin
            a = 24'($urandom); b = 24'($urandom);
            push(1, 1, a, b);
            wait_held(10);
            host_rd(3'd5, d);
        end
        repeat (3) cycle();
        host_rd(3'd7, d); chk("cnt_wrap", d, 8'h00);

        // Randomized traffic against the model
        host_wr(3'd7, 8'h03);
        for (int i = 0; i < 4000; i++) begin
            if (lq.size() < 4 && $urandom_range(3) == 0) push(1, 0, 24'($urandom), 24'h0);
            if (rq.size() < 4 && $urandom_range(3) == 0) push(0, 1, 24'h0, 24'($urandom));
            addr = 3'($urandom);
            rd = ($urandom_range(2) == 0);
            wr = ($urandom_range(7) == 0);
            din = 8'($urandom);
            if (wr && addr == 3'd7 && $urandom_range(3) != 0) din[0] = 1'b1;
            rst = ($urandom_range(499) == 0);
            cycle();
            rd = 1'b0; wr = 1'b0; rst = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/audio_fetch_ctrl.md
Name: audio_fetch_ctrl

Overview:
- Sequences the left/right audio sample FIFO pair on the host side: pops both FIFOs in lockstep and holds one stereo frame.
- Exposes the held frame as byte lanes on a small register window and frees the hold buffer when the host has consumed the frame.
- Sits between the Avalon-MM register stage (registered address/read/write/datain) and the two dual-clock audio FIFOs' read ports, all in the system clock domain.
- Also reports status and desync/underrun errors, and raises a frame-ready interrupt.

Parameters:
- ADDRESS_WIDTH, 3, host register address width (8 byte registers).
- DATA_WIDTH, 8, host data width. Fixed at 8; other values are unsupported.
- AUD_BIT_DEPTH, 24, sample width. Must equal 3*DATA_WIDTH.

Ports:
- clk  in  1  system clock; also the FIFO read clock.
- reset  in  1  synchronous, active-high reset.
- address  in  ADDRESS_WIDTH  registered host address.
- read  in  1  registered host read strobe, one cycle per access.
- write  in  1  registered host write strobe.
- datain  in  DATA_WIDTH  registered host write data.
- dataout  out  DATA_WIDTH  combinational read mux of the selected register.
- l_rdempty  in  1  left FIFO empty flag, clk domain.
- r_rdempty  in  1  right FIFO empty flag, clk domain.
- lsound_fifo  in  AUD_BIT_DEPTH  left FIFO q, valid the cycle after l_read.
- rsound_fifo  in  AUD_BIT_DEPTH  right FIFO q, valid the cycle after r_read.
- l_read  out  1  left FIFO pop.
- r_read  out  1  right FIFO pop.
- frame_irq  out  1  level; high while a frame is held and the interrupt enable is set.

Behaviour:
- Reset:
  - FSM goes to IDLE.
  - l_read=r_read=0, frame_irq=0.
  - Hold registers, flags, control bits and frame_cnt are all cleared.
  - Reset mid-operation discards any held frame. A pop already issued is lost; this is accepted.
- Control register (write, addr 7):
  - bit0 en, bit1 irq_en.
  - bit2 clr_err is a self-clearing pulse that clears the underrun and desync flags.
- FSM states:
  - IDLE: if en=1 and l_rdempty=0 and r_rdempty=0, go to POP.
    - If en=1 and exactly one FIFO is empty for 4 consecutive cycles, set desync=1 and stay in IDLE. No pop is issued.
  - POP: assert l_read=r_read=1 for exactly one cycle, then go to CAPTURE.
  - CAPTURE: latch lsound_fifo to lhold and rsound_fifo to rhold, set hold_valid=1, increment frame_cnt (8-bit, wraps 255->0), go to HOLD.
  - HOLD: wait for a host read of addr 5; then clear hold_valid and go to IDLE.
    - Minimum spacing between pops is therefore 3 cycles plus the host consume time.
- en cleared:
  - In IDLE: takes effect immediately.
  - In POP or CAPTURE: the sequence completes to HOLD.
  - In HOLD: the frame stays held until it is read out.
- Read map (dataout is a pure function of address and registers):
  - 0/1/2: lhold[7:0], [15:8], [23:16].
  - 3/4/5: rhold bytes in the same order.
  - 6: status {3'b0, desync, underrun, r_rdempty, l_rdempty, hold_valid}.
  - 7: frame_cnt.
- Consume rules:
  - A read of addr 5 with hold_valid=1 releases the frame.
  - A read of addr 5 with hold_valid=0 sets underrun=1 and returns stale rhold[23:16].
  - Reads of other addresses have no side effects.
- Simultaneous events:
  - clr_err together with a new underrun/desync event: the set wins.
  - Writes to addresses 0–6 are ignored.
- frame_irq = hold_valid & irq_en, registered, so it lags hold_valid by 1 cycle.

Decomposition:
- Shared package audio_pkg:
  - FSM state encoding: IDLE, POP, CAPTURE, HOLD.
  - Register address constants: ADDR_L0..ADDR_R2, ADDR_STAT, ADDR_CTRL.
  - Control bit indices.
  - DESYNC_CYCLES=4.
- One natural sub-module, audio_fetch_regs: control/status register file plus the read mux.
- The FSM stays in the top module.

Test Plan:
- Reset, then write ctrl=0x03, FIFOs non-empty with L=0x123456, R=0xABCDEF -> exactly one 1-cycle l_read/r_read pulse; reads 0..5 return 56,34,12,EF,CD,AB; frame_irq rises 1 cycle after hold_valid and drops after the addr-5 read.
- Preload FIFOs with 3 frames, en=1, host drains each frame fully -> 3 pops, each pop only after the previous addr-5 read; frame_cnt reads 3; FIFOs empty and FSM back in IDLE.
- Read addr 5 with no frame held -> status reads 0x08 (underrun); write ctrl=0x05 -> status returns 0x00 and en remains 1.
- Hold l_rdempty=0, r_rdempty=1 for 4 cycles with en=1 -> no pop; desync bit set at cycle 4. Three cycles of mismatch followed by recovery -> no desync.
- Assert reset while in HOLD -> hold_valid=0, frame_cnt=0, frame_irq=0 on the next cycle; no pop occurs until en is rewritten.
- frame_cnt wrap: 256 frames consumed -> frame_cnt reads 0x00.
